// File: rtl/cfg_pkg.sv
// Shared constants and helpers for the bit-bang configuration receiver.
// Control patterns and the shift-register word type live here.
package cfg_pkg;

  localparam int CFG_WORD_W = 32;

  localparam logic [CFG_WORD_W-1:0] CTRL_WORD_COMMIT = 32'h0000FAB1;
  localparam logic [CFG_WORD_W-1:0] CTRL_WORD_END    = 32'h0000FAB0;

  typedef logic [CFG_WORD_W-1:0] cfg_word_t;

  // Shift one wire bit in at the LSB; the oldest bit leaves at the MSB.
  function automatic cfg_word_t shift_in(input cfg_word_t sr, input logic b);
    return {sr[CFG_WORD_W-2:0], b};
  endfunction

endpackage

// File: rtl/cfg_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit, with rise/fall pulses
// derived from the synchronized level and a one-cycle-delayed copy.
module cfg_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic CLK,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/config_bitbang_rx.sv
// Bit-bang configuration receiver: data bits shift on s_clk rise, control
// bits on s_clk fall; a control window equal to CTRL_WORD commits the data word.
module config_bitbang_rx
  import cfg_pkg::*;
#(
  parameter int        SYNC_STAGES    = 2,
  parameter cfg_word_t CTRL_WORD      = CTRL_WORD_COMMIT,
  parameter int        TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  s_clk,
  input  logic                  s_data,
  output logic [CFG_WORD_W-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  active_o,
  output logic                  overrun_o
);

  localparam int             CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic s_clk_level, s_clk_rise, s_clk_fall;
  logic s_data_sync, s_data_rise, s_data_fall;

  cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (s_clk),
    .level  (s_clk_level),
    .rise   (s_clk_rise),
    .fall   (s_clk_fall)
  );

  // s_data goes through an identical chain so it stays aligned with s_clk.
  cfg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (s_data),
    .level  (s_data_sync),
    .rise   (s_data_rise),
    .fall   (s_data_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, s_clk_level, s_data_rise, s_data_fall};

  cfg_word_t        data_sr, ctrl_sr, ctrl_next;
  logic             commit_q;
  logic             commit_match, end_match;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_next;

  assign ctrl_next    = shift_in(ctrl_sr, s_data_sync);
  assign commit_match = s_clk_fall && (ctrl_next == CTRL_WORD);
  assign end_match    = s_clk_fall && (ctrl_next == CTRL_WORD_END);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    idle_cnt_next = idle_cnt;
    if (s_clk_rise || s_clk_fall) begin
      idle_cnt_next = '0;
    end else if (idle_cnt != TIMEOUT_CNT) begin
      idle_cnt_next = idle_cnt + CNT_W'(1);
    end
  end

  // Framing is a free-running 32-bit window; commits never clear it.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      data_sr  <= '0;
      ctrl_sr  <= '0;
      commit_q <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (s_clk_rise) begin
        data_sr <= shift_in(data_sr, s_data_sync);
      end
      if (s_clk_fall) begin
        ctrl_sr <= ctrl_next;
      end
      commit_q <= commit_match;
      idle_cnt <= idle_cnt_next;
    end
  end

  // Single-entry holding register toward the frame loader.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      word_o       <= '0;
      word_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else if (commit_q) begin
      if (!word_valid_o || word_ready_i) begin
        word_o       <= data_sr;
        word_valid_o <= 1'b1;
      end else begin
        overrun_o    <= 1'b1;
      end
    end else if (word_ready_i) begin
      word_valid_o <= 1'b0;
    end
  end

  // A commit opens the session; idle timeout or the end pattern closes it.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      active_o <= 1'b0;
    end else if (commit_q) begin
      active_o <= 1'b1;
    end else if (idle_cnt_next == TIMEOUT_CNT) begin
      active_o <= 1'b0;
    end else if (end_match) begin
      active_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_bitbang_rx.sv
// Randomized scoreboard bench for config_bitbang_rx: a bit-window model
// predicts committed words and their arrival cycle; a monitor checks them.
module tb_config_bitbang_rx;
  import cfg_pkg::*;

  localparam int SYNC    = 2;
  localparam int TIMEOUT = 4096;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        s_clk;
  logic        s_data;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        active_o;
  logic        overrun_o;

  config_bitbang_rx #(
    .SYNC_STAGES    (SYNC),
    .CTRL_WORD      (CTRL_WORD_COMMIT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .s_clk        (s_clk),
    .s_data       (s_data),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .active_o     (active_o),
    .overrun_o    (overrun_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] word;
    int          at_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: the last 32 data and control bits on the wire.
  logic [31:0] dwin = '0;
  logic [31:0] cwin = '0;
  bit          hold_full   = 1'b0;
  bit          overrun_exp = 1'b0;
  bit          collide     = 1'b0;
  int          last_fall   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_negedge(input int n);
    if (cyc > n) check("schedule_late", cyc, n);
    else do @(negedge CLK); while (cyc < n);
  endtask

  task automatic send_bit(input logic d, input logic c, input int hi, input int lo);
    s_data = d;
    step();
    s_clk = 1'b1;
    step();
    s_data = c;
    repeat (hi - 1) step();
    s_clk = 1'b0;
    last_fall = cyc;
    dwin = {dwin[30:0], d};
    cwin = {cwin[30:0], c};
    if (cwin == CTRL_WORD_COMMIT) begin
      if (!hold_full || word_ready_i || collide) begin
        exp_q.push_back('{word: dwin, at_cyc: last_fall + SYNC + 2});
        hold_full = !word_ready_i;
      end else begin
        overrun_exp = 1'b1;
      end
    end
    repeat (lo - 1) step();
  endtask

  task automatic send_word(input logic [31:0] d, input logic [31:0] c, input int hi, input int lo);
    for (int i = 31; i >= 0; i--) send_bit(d[i], c[i], hi, lo);
  endtask

  // Monitor: a new word is presented when valid is high and the previous
  // cycle either had no word or accepted it.
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b0;
  always @(negedge CLK) begin
    if (resetn === 1'b1) begin
      if (word_valid_o && (!prev_valid || prev_ready)) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got %h, expected none (cycle %0d)", word_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_value", word_o, e.word);
          check("word_cycle", cyc, e.at_cyc);
        end
      end
      prev_valid = word_valid_o;
      prev_ready = word_ready_i;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    s_clk        = 1'b0;
    s_data       = 1'b0;
    word_ready_i = 1'b1;
    repeat (3) step();
    at_negedge(cyc);
    check("rst_word",    word_o, 32'h0);
    check("rst_valid",   {31'b0, word_valid_o}, 32'h0);
    check("rst_active",  {31'b0, active_o}, 32'h0);
    check("rst_overrun", {31'b0, overrun_o}, 32'h0);
    step();
    resetn = 1'b1;
    repeat (2) step();

    // End pattern only: nothing commits and the session never opens.
    send_word(32'hDEADBEEF, CTRL_WORD_END, 2, 3);
    at_negedge(last_fall + 6);
    check("nocommit_active", {31'b0, active_o}, 32'h0);
    check("nocommit_valid",  {31'b0, word_valid_o}, 32'h0);
    step();

    // Single committed word.
    send_word(32'hDEADBEEF, CTRL_WORD_COMMIT, 2, 3);
    at_negedge(last_fall + SYNC + 2);
    check("single_active", {31'b0, active_o}, 32'h1);
    step();

    // End word closes the session on its final fall.
    send_word($urandom, CTRL_WORD_END, 2, 3);
    at_negedge(last_fall + SYNC);
    check("end_active_before", {31'b0, active_o}, 32'h1);
    at_negedge(last_fall + SYNC + 1);
    check("end_active_after", {31'b0, active_o}, 32'h0);
    step();

    // Idle timeout after a commit.
    send_word($urandom, CTRL_WORD_COMMIT, 3, 4);
    begin
      int drop;
      drop = last_fall + SYNC + 1 + TIMEOUT;
      at_negedge(drop - 1);
      check("timeout_active_before", {31'b0, active_o}, 32'h1);
      at_negedge(drop);
      check("timeout_active_at", {31'b0, active_o}, 32'h0);
    end
    step();

    // Accept and commit in the same cycle.
    word_ready_i = 1'b0;
    step();
    send_word(32'h22222222, CTRL_WORD_COMMIT, 2, 3);
    repeat (4) step();
    collide = 1'b1;
    send_word(32'h33333333, CTRL_WORD_COMMIT, 2, 3);
    while (cyc < last_fall + SYNC + 1) step();
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    collide = 1'b0;
    at_negedge(last_fall + SYNC + 2);
    check("collide_word",    word_o, 32'h33333333);
    check("collide_valid",   {31'b0, word_valid_o}, 32'h1);
    check("collide_overrun", {31'b0, overrun_o}, {31'b0, overrun_exp});
    step();
    word_ready_i = 1'b1;
    hold_full = 1'b0;
    step();
    at_negedge(cyc);
    check("collide_drain_valid", {31'b0, word_valid_o}, 32'h0);
    step();

    // Backpressure: second word is lost, first one is held.
    word_ready_i = 1'b0;
    step();
    send_word(32'h11111111, CTRL_WORD_COMMIT, 2, 3);
    send_word(32'h22222222, CTRL_WORD_COMMIT, 2, 3);
    at_negedge(last_fall + SYNC + 3);
    check("bp_word",    word_o, 32'h11111111);
    check("bp_valid",   {31'b0, word_valid_o}, 32'h1);
    check("bp_overrun", {31'b0, overrun_o}, {31'b0, overrun_exp});
    step();
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    hold_full = 1'b0;
    at_negedge(cyc);
    check("bp_drain_valid", {31'b0, word_valid_o}, 32'h0);
    step();

    // Randomized words and phase timing with the loader always ready.
    word_ready_i = 1'b1;
    step();
    for (int n = 0; n < 10; n++) begin
      logic [31:0] c;
      c = ($urandom_range(0, 3) == 0) ? 32'($urandom) : CTRL_WORD_COMMIT;
      send_word($urandom, c, $urandom_range(2, 4), $urandom_range(3, 5));
    end
    repeat (8) step();
    at_negedge(cyc);
    check("overrun_sticky", {31'b0, overrun_o}, {31'b0, overrun_exp});
    check("queue_drained", exp_q.size(), 32'h0);
    step();

    // Reset in the middle of a word.
    for (int i = 0; i < 13; i++) send_bit(1'($urandom), 1'($urandom), 2, 3);
    resetn = 1'b0;
    repeat (2) step();
    at_negedge(cyc);
    check("midrst_word",    word_o, 32'h0);
    check("midrst_valid",   {31'b0, word_valid_o}, 32'h0);
    check("midrst_active",  {31'b0, active_o}, 32'h0);
    check("midrst_overrun", {31'b0, overrun_o}, 32'h0);
    dwin = '0;
    cwin = '0;
    hold_full = 1'b0;
    overrun_exp = 1'b0;
    exp_q.delete();
    step();
    resetn = 1'b1;
    repeat (2) step();
    send_word(32'hCAFEF00D, CTRL_WORD_COMMIT, 2, 3);
    repeat (8) step();
    at_negedge(cyc);
    check("final_queue_drained", exp_q.size(), 32'h0);
    check("final_overrun", {31'b0, overrun_o}, 32'h0);
    check("final_active",  {31'b0, active_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
